// File: rtl/phys_reg_freelist_pkg.sv
// Package for the physical register free list.
// Holds the rename/commit sizing parameters, the physical tag type and the
// prefix-popcount helper used to compact push lanes and count pops.
// Optional build macro used by the free list: FREELIST_CHECK_EN.
package phys_reg_freelist_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS            = 64;
    localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
    localparam int ARCH_REGS            = 32;
    localparam int FREELIST_DEPTH       = PHYS_REGS - ARCH_REGS;
    localparam int FREELIST_PTR_WIDTH   = $clog2(FREELIST_DEPTH) + 1;
    // Width wide enough to hold a count of 0..DISPATCH_WIDTH lanes.
    localparam int LANE_CNT_WIDTH       = $clog2(DISPATCH_WIDTH + 1);

    typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;

    // Number of set bits in en[lane-1:0]. With lane == DISPATCH_WIDTH this is
    // the full popcount of the enable vector.
    function automatic logic [LANE_CNT_WIDTH-1:0] lane_offset(
        input logic [DISPATCH_WIDTH-1:0] en,
        input int unsigned               lane
    );
        logic [LANE_CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int unsigned j = 0; j < DISPATCH_WIDTH; j++) begin
            if ((j < lane) && en[j]) begin
                cnt = cnt + 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register tags between commit and rename.
// Commit pushes released tags, rename pops fresh tags; num_free_o lets rename
// stall. The list starts full with tags ARCH_REGS..PHYS_REGS-1.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous reset, active-high
//   push_reg_i  in   [DISPATCH_WIDTH][AW] tags released by commit
//   push_en_i   in   [DISPATCH_WIDTH] per-lane push valid, any bit pattern
//   pop_reg_o   out  [DISPATCH_WIDTH][AW] next free tags, lane i = i-th oldest
//   pop_en_i    in   [DISPATCH_WIDTH] per-lane consume, contiguous from lane 0
//   num_free_o  out  [AW:0] number of tags currently free
//   err_o       out  sticky misuse flag (only when FREELIST_CHECK_EN is defined)
//
// Handshake: pop_reg_o[i] is a valid tag only for i < num_free_o. Rename
// consumes by raising pop_en_i for the lowest lanes in the cycle it uses the
// tags; commit presents push_reg_i with push_en_i and the tags are accepted at
// that edge unconditionally. There is no ready on the push side: commit can
// never release more tags than rename has taken.
//
// Build option FREELIST_CHECK_EN: adds err_o plus simulation assertions for
// over-pop, over-push, non-thermometer pop_en_i and pushing tag 0.
module phys_reg_freelist
    import phys_reg_freelist_pkg::*;
(
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] push_reg_i,
    input  logic [DISPATCH_WIDTH-1:0]                           push_en_i,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] pop_reg_o,
    input  logic [DISPATCH_WIDTH-1:0]                           pop_en_i,
`ifdef FREELIST_CHECK_EN
    output logic                                                err_o,
`endif
    output logic [PHYS_REGS_ADDR_WIDTH:0]                       num_free_o
);

    localparam int PW = FREELIST_PTR_WIDTH;
    localparam int IW = FREELIST_PTR_WIDTH - 1;
    localparam int CW = PHYS_REGS_ADDR_WIDTH + 1;

    phys_reg_t         buf_q [FREELIST_DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     num_free_q, num_free_d;

    logic [LANE_CNT_WIDTH-1:0] pop_cnt;
    logic [LANE_CNT_WIDTH-1:0] push_cnt;
    logic [IW-1:0]             rd_idx [DISPATCH_WIDTH];
    logic [IW-1:0]             wr_idx [DISPATCH_WIDTH];

    always_comb begin
        pop_cnt    = lane_offset(pop_en_i, DISPATCH_WIDTH);
        push_cnt   = lane_offset(push_en_i, DISPATCH_WIDTH);
        // Pointers carry a wrap bit, so plain modular adds give full/empty.
        head_d     = head_q + PW'(pop_cnt);
        tail_d     = tail_q + PW'(push_cnt);
        num_free_d = num_free_q + CW'(push_cnt) - CW'(pop_cnt);
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            rd_idx[i]    = head_q[IW-1:0] + IW'(i);
            pop_reg_o[i] = buf_q[rd_idx[i]];
            // Enabled push lanes pack densely starting at the old tail.
            wr_idx[i]    = tail_q[IW-1:0] + IW'(lane_offset(push_en_i, i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FREELIST_DEPTH; k++) begin
                buf_q[k] <= phys_reg_t'(ARCH_REGS + k);
            end
            head_q     <= '0;
            // Wrap bit set with equal index bits: list starts full.
            tail_q     <= {1'b1, {IW{1'b0}}};
            num_free_q <= CW'(FREELIST_DEPTH);
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            num_free_q <= num_free_d;
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (push_en_i[i]) begin
                    buf_q[wr_idx[i]] <= push_reg_i[i];
                end
            end
        end
    end

    assign num_free_o = num_free_q;

`ifdef FREELIST_CHECK_EN
    localparam int SW = CW + 1;

    logic err_q, err_d;
    logic pop_over, push_over, pop_gap, push_zero;

    always_comb begin
        pop_over  = CW'(pop_cnt) > num_free_q;
        // Compare num_free+push > DEPTH+pop so the check cannot underflow.
        push_over = (SW'(num_free_q) + SW'(push_cnt)) >
                    (SW'(FREELIST_DEPTH) + SW'(pop_cnt));
        pop_gap   = 1'b0;
        push_zero = 1'b0;
        for (int j = 1; j < DISPATCH_WIDTH; j++) begin
            if (pop_en_i[j] && !pop_en_i[j-1]) begin
                pop_gap = 1'b1;
            end
        end
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (push_en_i[i] && (push_reg_i[i] == '0)) begin
                push_zero = 1'b1;
            end
        end
        err_d = err_q | pop_over | push_over | pop_gap | push_zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!pop_over)  else $warning("freelist: pop beyond num_free");
            assert (!push_over) else $warning("freelist: push beyond depth");
            assert (!pop_gap)   else $warning("freelist: non-thermometer pop_en");
            assert (!push_zero) else $warning("freelist: push of tag 0");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_phys_reg_freelist.sv
module tb_phys_reg_freelist;
  import phys_reg_freelist_pkg::*;

  logic clk;
  logic rst;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] push_reg;
  logic [DISPATCH_WIDTH-1:0] push_en;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] pop_reg;
  logic [DISPATCH_WIDTH-1:0] pop_en;
  logic [PHYS_REGS_ADDR_WIDTH:0] num_free;
`ifdef FREELIST_CHECK_EN
  logic err;
`endif

  int checks;
  int failures;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] exp_q[$];

  phys_reg_freelist dut (
    .clk        (clk),
    .rst        (rst),
    .push_reg_i (push_reg),
    .push_en_i  (push_en),
    .pop_reg_o  (pop_reg),
    .pop_en_i   (pop_en),
`ifdef FREELIST_CHECK_EN
    .err_o      (err),
`endif
    .num_free_o (num_free)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: present inputs, take the edge, drop inputs 1 time unit later.
  task automatic tick(input logic [1:0] pe, input logic [1:0] ue,
                      input logic [5:0] r0, input logic [5:0] r1);
    pop_en      = pe;
    push_en     = ue;
    push_reg[0] = r0;
    push_reg[1] = r1;
    @(posedge clk);
    #1;
    pop_en   = '0;
    push_en  = '0;
    push_reg = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pop_en   = '0;
    push_en  = '0;
    push_reg = '0;
    repeat (2) @(negedge clk);

    // 1: reset state
    check("reset_num_free", 32'(num_free), 32);
    check("reset_pop0", 32'(pop_reg[0]), 32);
    check("reset_pop1", 32'(pop_reg[1]), 33);
`ifdef FREELIST_CHECK_EN
    check("reset_err", 32'(err), 0);
`endif
    rst = 1'b0;

    // 2: pop two
    tick(2'b11, 2'b00, 6'd0, 6'd0);
    check("pop2_num_free", 32'(num_free), 30);
    check("pop2_pop0", 32'(pop_reg[0]), 34);
    check("pop2_pop1", 32'(pop_reg[1]), 35);

    // 3: sparse push on lane 1 with one pop; tag 9 lands at buf[0]
    tick(2'b01, 2'b10, 6'd0, 6'd9);
    check("pushpop_num_free", 32'(num_free), 30);
    check("pushpop_pop0", 32'(pop_reg[0]), 35);
    check("pushpop_pop1", 32'(pop_reg[1]), 36);

    // 4: drain; 14 pairs leave tags 63 and 9 as the last two
    for (int k = 0; k < 14; k++) tick(2'b11, 2'b00, 6'd0, 6'd0);
    check("drain_num_free", 32'(num_free), 2);
    check("drain_pop0", 32'(pop_reg[0]), 63);
    check("drain_pop1", 32'(pop_reg[1]), 9);
    tick(2'b11, 2'b00, 6'd0, 6'd0);
    check("empty_num_free", 32'(num_free), 0);

    // push into empty list; visible only after the edge
    tick(2'b00, 2'b11, 6'd5, 6'd7);
    check("refill_num_free", 32'(num_free), 2);
    check("refill_pop0", 32'(pop_reg[0]), 5);
    check("refill_pop1", 32'(pop_reg[1]), 7);
    exp_q.push_back(6'd5);
    exp_q.push_back(6'd7);

    // streaming push/pop across the index wrap, FIFO order from exp_q
    for (int k = 0; k < 20; k++) begin
      logic [5:0] a, b;
      a = 6'(10 + 2 * k);
      b = 6'(11 + 2 * k);
      check("stream_pop0", 32'(pop_reg[0]), 32'(exp_q[0]));
      check("stream_pop1", 32'(pop_reg[1]), 32'(exp_q[1]));
      tick(2'b11, 2'b11, a, b);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_q.push_back(a);
      exp_q.push_back(b);
      check("stream_num_free", 32'(num_free), 2);
    end
    check("stream_end_pop0", 32'(pop_reg[0]), 48);
    check("stream_end_pop1", 32'(pop_reg[1]), 49);

    // single-lane push on lane 0 only
    tick(2'b00, 2'b01, 6'd50, 6'd0);
    check("push01_num_free", 32'(num_free), 3);
    // build up to 10 free
    tick(2'b00, 2'b11, 6'd51, 6'd52);
    tick(2'b00, 2'b11, 6'd53, 6'd54);
    tick(2'b00, 2'b11, 6'd55, 6'd56);
    tick(2'b00, 2'b01, 6'd57, 6'd0);
    check("prefill_num_free", 32'(num_free), 10);
    check("prefill_pop0", 32'(pop_reg[0]), 48);

    // 5: async reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_num_free", 32'(num_free), 32);
    check("async_pop0", 32'(pop_reg[0]), 32);
    check("async_pop1", 32'(pop_reg[1]), 33);
    @(negedge clk);
    rst = 1'b0;

`ifdef FREELIST_CHECK_EN
    // 6: over-pop at num_free=1
    for (int k = 0; k < 15; k++) tick(2'b11, 2'b00, 6'd0, 6'd0);
    tick(2'b01, 2'b00, 6'd0, 6'd0);
    check("chk_num_free", 32'(num_free), 1);
    check("chk_err_clear", 32'(err), 0);
    tick(2'b11, 2'b00, 6'd0, 6'd0);
    check("chk_err_overpop", 32'(err), 1);
    tick(2'b00, 2'b00, 6'd0, 6'd0);
    check("chk_err_sticky", 32'(err), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("chk_err_reset", 32'(err), 0);
    tick(2'b10, 2'b00, 6'd0, 6'd0);
    check("chk_err_gap", 32'(err), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
